stencil_output_collector: RTL and testbench

Receives the raw per-cycle pixel stream leaving a stencil pipeline on its `out_output_write` / `out_output_write_en` port. Tracks the frame position with row and column counters and drops the invalid border pixels produced by the cascaded 3x3 stages. Buffers the surviving pixels in a small FIFO and presents them downstream on a valid/ready stream with an end-of-frame marker. The pipeline has no backpressure, so overflow is detected and flagged rather than prevented.

---
 rtl/stencil_output_collector_if.sv | 27 ++
 rtl/stencil_output_collector.sv | 122 ++++++++++++
 tb/tb_stencil_output_collector.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stencil_output_collector_if.sv
// Connection bundle for the stencil output collector: raw pipeline strobe in,
// cropped valid/ready stream plus status out.
interface stencil_output_collector_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  logic                     out_output_write_en;
  logic [WIDTH-1:0]         out_output_write;
  logic                     m_valid;
  logic                     m_ready;
  logic [WIDTH-1:0]         m_data;
  logic                     m_last;
  logic                     frame_done;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   level;

  // The collector is the master of the downstream stream.
  modport master (
    input  out_output_write_en, out_output_write, m_ready,
    output m_valid, m_data, m_last, frame_done, overflow, level
  );

  modport slave (
    output out_output_write_en, out_output_write, m_ready,
    input  m_valid, m_data, m_last, frame_done, overflow, level
  );
endinterface

// File: rtl/stencil_output_collector.sv
// Crops the invalid leading rows/columns of a stencil pipeline's output and
// buffers the surviving pixels in a small FIFO behind a valid/ready stream.
module stencil_output_collector #(
  parameter int WIDTH = 16,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CROP  = 4,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  stencil_output_collector_if.master  bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] CROP_COL = CW'(CROP);
  localparam logic [RW-1:0] CROP_ROW = RW'(CROP);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LW-1:0]  level_q;
  logic [WIDTH:0] mem [DEPTH];
  logic           frame_done_q;
  logic           overflow_q;

  logic at_col_end;
  logic at_row_end;
  logic pix_last;
  logic kept;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Keep/last decisions use the counter values before this strobe advances them.
  always_comb begin
    at_col_end = 1'b0;
    at_row_end = 1'b0;
    pix_last   = 1'b0;
    kept       = 1'b0;
    full       = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;

    at_col_end = (col == COL_MAX);
    at_row_end = (row == ROW_MAX);
    pix_last   = at_col_end && at_row_end;
    kept       = bus.out_output_write_en && (col >= CROP_COL) && (row >= CROP_ROW);
    full       = (level_q == FULL_LVL);
    pop        = (level_q != '0) && bus.m_ready;
    push       = kept && (!full || pop);
    drop       = kept && full && !pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (bus.out_output_write_en) begin
      if (at_col_end) begin
        col <= '0;
        row <= at_row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {bus.out_output_write, pix_last};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= bus.out_output_write_en && pix_last;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.m_valid              = (level_q != '0);
  assign {bus.m_data, bus.m_last} = mem[rd_ptr];
  assign bus.frame_done           = frame_done_q;
  assign bus.overflow             = overflow_q;
  assign bus.level                = level_q;

endmodule

// File: tb/tb_stencil_output_collector.sv
// Scoreboard bench for stencil_output_collector on a small 8x6 frame with CROP=4.
module tb_stencil_output_collector;

  localparam int WIDTH = 16;
  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int CROP  = 4;
  localparam int DEPTH = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stencil_output_collector_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stencil_output_collector #(
    .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .CROP(CROP), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [WIDTH:0]   sb[$];
  logic [WIDTH-1:0] seen[$];
  int pop_count = 0;
  int last_count = 0;
  int fd_count = 0;
  int mdl_level = 0;
  bit mdl_overflow = 0;
  bit exp_valid = 0;
  bit fd_exp = 0;
  bit prev_last_strobe = 0;
  bit stall_prev = 0;
  bit tog = 0;
  logic [WIDTH:0] held;
  int exp_list[8] = '{36, 37, 38, 39, 44, 45, 46, 47};

  // Drives one cycle of stimulus and advances the reference FIFO model.
  task automatic drive(input bit en, input logic [WIDTH-1:0] data, input bit kept,
                       input bit last, input bit rdy);
    bit pop_m;
    bit push_m;
    @(posedge clk);
    #1;
    bus.out_output_write_en = en;
    bus.out_output_write    = data;
    bus.m_ready             = rdy;
    exp_valid        = (mdl_level != 0);
    fd_exp           = prev_last_strobe;
    prev_last_strobe = en && last;
    pop_m  = exp_valid && rdy;
    push_m = en && kept && ((mdl_level < DEPTH) || pop_m);
    if (en && kept && !push_m) mdl_overflow = 1'b1;
    if (push_m) sb.push_back({data, last});
    mdl_level = mdl_level + int'(push_m) - int'(pop_m);
  endtask

  function automatic bit next_rdy(input int mode);
    if (mode == 2) begin
      tog = ~tog;
      return tog;
    end
    return (mode == 0);
  endfunction

  task automatic run_frame(input int offset, input bit gaps, input int rdy_mode,
                           input int first, input int stop);
    for (int p = first; p < stop; p++) begin
      int r;
      int c;
      r = p / IMG_W;
      c = p % IMG_W;
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
          drive(1'b0, '0, 1'b0, 1'b0, next_rdy(rdy_mode));
        end
      end
      drive(1'b1, WIDTH'(r * IMG_W + c + offset), (r >= CROP && c >= CROP),
            (r == IMG_H - 1 && c == IMG_W - 1), next_rdy(rdy_mode));
    end
  endtask

  task automatic drain(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_output_write_en = 1'b0;
    bus.out_output_write    = '0;
    bus.m_ready             = 1'b0;
    sb.delete();
    mdl_level        = 0;
    mdl_overflow     = 1'b0;
    exp_valid        = 1'b0;
    fd_exp           = 1'b0;
    prev_last_strobe = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: compares every pop, the valid flag, frame_done, and stall holding.
  always @(negedge clk) begin
    logic [WIDTH:0] exp;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      checks++;
      if (bus.m_valid !== exp_valid) begin
        errors++;
        $display("[TB] FAIL m_valid: got %b expected %b", bus.m_valid, exp_valid);
      end
      checks++;
      if (bus.frame_done !== fd_exp) begin
        errors++;
        $display("[TB] FAIL frame_done: got %b expected %b", bus.frame_done, fd_exp);
      end
      if (bus.frame_done === 1'b1) fd_count++;
      if (stall_prev) begin
        checks++;
        if ({bus.m_data, bus.m_last} !== held) begin
          errors++;
          $display("[TB] FAIL stall_hold: got %h expected %h", {bus.m_data, bus.m_last}, held);
        end
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        pop_count++;
        if (bus.m_last === 1'b1) last_count++;
        seen.push_back(bus.m_data);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_pop: got data %0d expected no output", bus.m_data);
        end else begin
          exp = sb.pop_front();
          if ({bus.m_data, bus.m_last} !== exp) begin
            errors++;
            $display("[TB] FAIL pop_data: got data %0d last %b expected data %0d last %b",
                     bus.m_data, bus.m_last, exp[WIDTH:1], exp[0]);
          end
        end
      end
      stall_prev = (bus.m_valid === 1'b1 && bus.m_ready === 1'b0);
      held = {bus.m_data, bus.m_last};
    end
  end

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.m_valid); end
    if (bus.m_data !== '0) begin errors++; $display("[TB] FAIL rst_data: got %0d expected 0", bus.m_data); end
    if (bus.m_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_last: got %b expected 0", bus.m_last); end
    if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done: got %b expected 0", bus.frame_done); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_overflow: got %b expected 0", bus.overflow); end
    if (bus.level !== '0) begin errors++; $display("[TB] FAIL rst_level: got %0d expected 0", bus.level); end
    release_reset();
  endtask

  task automatic test_stream();
    int p0, l0, f0;
    p0 = pop_count; l0 = last_count; f0 = fd_count;
    seen.delete();
    run_frame(0, 1'b0, 0, 0, NPIX);
    drain(4);
    checks += 4;
    if (pop_count - p0 != 8) begin errors++; $display("[TB] FAIL stream_pops: got %0d expected 8", pop_count - p0); end
    if (last_count - l0 != 1) begin errors++; $display("[TB] FAIL stream_last: got %0d expected 1", last_count - l0); end
    if (fd_count - f0 != 1) begin errors++; $display("[TB] FAIL stream_frame_done: got %0d expected 1", fd_count - f0); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL stream_overflow: got %b expected 0", bus.overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= seen.size() || seen[i] !== WIDTH'(exp_list[i])) begin
        errors++;
        $display("[TB] FAIL stream_order[%0d]: got %0d expected %0d", i,
                 (i < seen.size()) ? int'(seen[i]) : -1, exp_list[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int p0, l0, f0;
    p0 = pop_count; l0 = last_count; f0 = fd_count;
    run_frame(0, 1'b0, 0, 0, NPIX);
    run_frame(100, 1'b0, 0, 0, NPIX);
    drain(4);
    checks += 4;
    if (pop_count - p0 != 16) begin errors++; $display("[TB] FAIL b2b_pops: got %0d expected 16", pop_count - p0); end
    if (last_count - l0 != 2) begin errors++; $display("[TB] FAIL b2b_last: got %0d expected 2", last_count - l0); end
    if (fd_count - f0 != 2) begin errors++; $display("[TB] FAIL b2b_frame_done: got %0d expected 2", fd_count - f0); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overflow: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_toggle();
    int p0, l0;
    p0 = pop_count; l0 = last_count;
    tog = 1'b0;
    run_frame(0, 1'b0, 2, 0, NPIX);
    drain(6);
    checks += 3;
    if (pop_count - p0 != 8) begin errors++; $display("[TB] FAIL toggle_pops: got %0d expected 8", pop_count - p0); end
    if (last_count - l0 != 1) begin errors++; $display("[TB] FAIL toggle_last: got %0d expected 1", last_count - l0); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL toggle_overflow: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_gaps();
    int f0;
    f0 = fd_count;
    seen.delete();
    run_frame(0, 1'b1, 0, 0, NPIX);
    drain(4);
    checks += 2;
    if (seen.size() != 8) begin errors++; $display("[TB] FAIL gaps_count: got %0d expected 8", seen.size()); end
    if (fd_count - f0 != 1) begin errors++; $display("[TB] FAIL gaps_frame_done: got %0d expected 1", fd_count - f0); end
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== WIDTH'(exp_list[i])) begin
        errors++;
        $display("[TB] FAIL gaps_order[%0d]: got %0d expected %0d", i, seen[i], exp_list[i]);
      end
    end
  endtask

  task automatic test_push_pop_full();
    int p0;
    p0 = pop_count;
    run_frame(0, 1'b0, 1, 0, 44);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.level !== 3'(DEPTH)) begin errors++; $display("[TB] FAIL ppf_fill_level: got %0d expected %0d", bus.level, DEPTH); end
    run_frame(0, 1'b0, 0, 44, 45);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (bus.level !== 3'(DEPTH)) begin errors++; $display("[TB] FAIL ppf_level: got %0d expected %0d", bus.level, DEPTH); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ppf_overflow: got %b expected 0", bus.overflow); end
    run_frame(0, 1'b0, 0, 45, NPIX);
    drain(6);
    checks += 2;
    if (pop_count - p0 != 8) begin errors++; $display("[TB] FAIL ppf_pops: got %0d expected 8", pop_count - p0); end
    if (bus.level !== '0) begin errors++; $display("[TB] FAIL ppf_drain_level: got %0d expected 0", bus.level); end
  endtask

  task automatic test_overflow();
    int p0;
    p0 = pop_count;
    run_frame(0, 1'b0, 1, 0, 40);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (bus.level !== 3'(DEPTH)) begin errors++; $display("[TB] FAIL ovf_level_after_39: got %0d expected %0d", bus.level, DEPTH); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b expected 0", bus.overflow); end
    run_frame(0, 1'b0, 1, 40, NPIX);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (bus.overflow !== mdl_overflow) begin errors++; $display("[TB] FAIL ovf_set: got %b expected %b", bus.overflow, mdl_overflow); end
    if (bus.level !== 3'(DEPTH)) begin errors++; $display("[TB] FAIL ovf_level: got %0d expected %0d", bus.level, DEPTH); end
    drain(6);
    checks += 4;
    if (pop_count - p0 != 4) begin errors++; $display("[TB] FAIL ovf_pops: got %0d expected 4", pop_count - p0); end
    if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_valid_fall: got %b expected 0", bus.m_valid); end
    if (bus.level !== '0) begin errors++; $display("[TB] FAIL ovf_drain_level: got %0d expected 0", bus.level); end
    if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", bus.overflow); end
  endtask

  task automatic test_reset_mid_frame();
    int p0, f0;
    run_frame(0, 1'b0, 1, 0, 42);
    do_reset();
    checks += 4;
    if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", bus.m_valid); end
    if (bus.level !== '0) begin errors++; $display("[TB] FAIL mid_rst_level: got %0d expected 0", bus.level); end
    if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_overflow: got %b expected 0", bus.overflow); end
    if (bus.m_data !== '0) begin errors++; $display("[TB] FAIL mid_rst_data: got %0d expected 0", bus.m_data); end
    release_reset();
    p0 = pop_count; f0 = fd_count;
    seen.delete();
    run_frame(0, 1'b0, 0, 0, NPIX);
    drain(4);
    checks += 2;
    if (pop_count - p0 != 8) begin errors++; $display("[TB] FAIL replay_pops: got %0d expected 8", pop_count - p0); end
    if (fd_count - f0 != 1) begin errors++; $display("[TB] FAIL replay_frame_done: got %0d expected 1", fd_count - f0); end
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== WIDTH'(exp_list[i])) begin
        errors++;
        $display("[TB] FAIL replay_order[%0d]: got %0d expected %0d", i, seen[i], exp_list[i]);
      end
    end
  endtask

  initial begin
    bus.out_output_write_en = 1'b0;
    bus.out_output_write    = '0;
    bus.m_ready             = 1'b0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_toggle();
    test_gaps();
    test_push_pop_full();
    test_overflow();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
